// File: rtl/reg_transfer_ctrl.sv
// Register-file sequencer for 6502 transfer (TAX..TXS) and load-immediate ops.
// Owns the file's single port while busy: read source, write destination, update PSR N/Z.
module reg_transfer_ctrl #(
  parameter logic [2:0] PSR_SEL = 3'd6
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [3:0] op_i,
  input  logic [7:0] imm_i,
  output logic [2:0] rf_sel_o,
  output logic       rf_load_o,
  output logic [7:0] rf_wdata_o,
  input  logic [7:0] rf_rdata_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o,
  output logic [7:0] result_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_SRC, S_CAP_SRC, S_WR_DST, S_RD_PSR, S_CAP_PSR, S_WR_PSR, S_DONE
  } state_t;

  localparam logic [3:0] OP_TXS     = 4'd5;
  localparam logic [3:0] OP_LAST_XF = 4'd5;
  localparam logic [3:0] OP_LAST    = 4'd8;

  state_t     state_q, state_d;
  logic [3:0] op_q;
  logic [7:0] val_q, psr_q, result_q;
  logic       error_q;
  logic [2:0] src_sel, dst_sel;
  logic       op_legal, accept;

  assign op_legal = (op_i <= OP_LAST);
  assign accept   = (state_q == S_IDLE) && start_i && op_legal;

  always_comb begin
    src_sel = 3'd0;
    dst_sel = 3'd0;
    case (op_q)
      4'd0: begin src_sel = 3'd0; dst_sel = 3'd1; end
      4'd1: begin src_sel = 3'd1; dst_sel = 3'd0; end
      4'd2: begin src_sel = 3'd0; dst_sel = 3'd2; end
      4'd3: begin src_sel = 3'd2; dst_sel = 3'd0; end
      4'd4: begin src_sel = 3'd3; dst_sel = 3'd1; end
      4'd5: begin src_sel = 3'd1; dst_sel = 3'd3; end
      4'd6: dst_sel = 3'd0;
      4'd7: dst_sel = 3'd1;
      4'd8: dst_sel = 3'd2;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      op_q     <= 4'd0;
      val_q    <= 8'd0;
      psr_q    <= 8'd0;
      result_q <= 8'd0;
      error_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      error_q <= (state_q == S_IDLE) && start_i && !op_legal;
      if (accept) begin
        op_q <= op_i;
        if (op_i > OP_LAST_XF) val_q <= imm_i;
      end
      if (state_q == S_CAP_SRC) val_q    <= rf_rdata_i;
      if (state_q == S_CAP_PSR) psr_q    <= rf_rdata_i;
      if (state_q == S_DONE)    result_q <= val_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    rf_sel_o   = 3'd0;
    rf_load_o  = 1'b0;
    rf_wdata_o = 8'd0;
    busy_o     = 1'b1;
    done_o     = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        if (accept) state_d = (op_i > OP_LAST_XF) ? S_WR_DST : S_RD_SRC;
      end
      S_RD_SRC: begin
        rf_sel_o = src_sel;
        state_d  = S_CAP_SRC;
      end
      S_CAP_SRC: begin
        rf_sel_o = src_sel;
        state_d  = S_WR_DST;
      end
      S_WR_DST: begin
        rf_sel_o   = dst_sel;
        rf_load_o  = 1'b1;
        rf_wdata_o = val_q;
        state_d    = (op_q == OP_TXS) ? S_DONE : S_RD_PSR;
      end
      S_RD_PSR: begin
        rf_sel_o = PSR_SEL;
        state_d  = S_CAP_PSR;
      end
      S_CAP_PSR: begin
        rf_sel_o = PSR_SEL;
        state_d  = S_WR_PSR;
      end
      S_WR_PSR: begin
        // only N and Z are recomputed; every other flag passes through
        rf_sel_o   = PSR_SEL;
        rf_load_o  = 1'b1;
        rf_wdata_o = {val_q[7], psr_q[6:2], (val_q == 8'd0), psr_q[0]};
        state_d    = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign error_o  = error_q;
  assign result_o = (state_q == S_DONE) ? val_q : result_q;

endmodule

// File: doc/reg_transfer_ctrl.md
# reg_transfer_ctrl

Sequencer that drives the CPU register file's single read/write port (`regSelect`/`load`/`dataIn`/`dataOut`) to execute 6502 register-transfer and load-immediate operations. It reads the source register, writes the destination, and read-modify-writes PSR N/Z. It sits between the instruction decoder and the register file: it is the initiator for the file's responder port, and the only port user while `busy` is high.

## Interface
Parameters:
- `PSR_SEL`, default 3'd6: register-file select code of PSR.

Ports:
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request; sampled only in IDLE.
- `op` in 4: operation code. 0 TAX, 1 TXA, 2 TAY, 3 TYA, 4 TSX, 5 TXS, 6 LDA#, 7 LDX#, 8 LDY#. Codes 9–15 are illegal.
- `imm` in 8: immediate operand for ops 6–8.
- `rf_sel` out 3: to register file `regSelect`. Codes: 0 Acc, 1 X, 2 Y, 3 SP, 6 PSR.
- `rf_load` out 1: to register file `load`.
- `rf_wdata` out 8: to register file `dataIn`.
- `rf_rdata` in 8: from register file `dataOut`. It is registered in the file: valid the cycle after `rf_sel` is presented with `rf_load`=0.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse on completion.
- `error` out 1: one-cycle pulse when `start` arrives with an illegal op.
- `result` out 8: last value transferred. Holds until the next accepted op.

## Operation
- FSM states: IDLE, RD_SRC, CAP_SRC, WR_DST, RD_PSR, CAP_PSR, WR_PSR, DONE.
- IDLE: `rf_sel`=0, `rf_load`=0, `rf_wdata`=0.
  - `start` with a legal op latches `op` and `imm`.
  - Transfer ops (0–5) go to RD_SRC.
  - Immediate ops (6–8) load `val_q`=`imm` and go to WR_DST.
- Source/destination mapping:
  - TAX A→X; TXA X→A; TAY A→Y; TYA Y→A; TSX SP→X; TXS X→SP.
  - LDA/LDX/LDY target A/X/Y.
- RD_SRC: `rf_sel`=src, `rf_load`=0. Next state CAP_SRC.
- CAP_SRC: `rf_sel`=src, `rf_load`=0. `val_q` <= `rf_rdata`. Next state WR_DST.
- WR_DST: `rf_sel`=dst, `rf_load`=1, `rf_wdata`=`val_q`. Next state DONE for TXS, else RD_PSR.
- RD_PSR: `rf_sel`=`PSR_SEL`, `rf_load`=0. Next state CAP_PSR.
- CAP_PSR: same drive as RD_PSR. `psr_q` <= `rf_rdata`. Next state WR_PSR.
- WR_PSR: `rf_sel`=`PSR_SEL`, `rf_load`=1, `rf_wdata`={`val_q`[7], `psr_q`[6:2], (`val_q`==0), `psr_q`[0]}.
  - Only N (bit 7) and Z (bit 1) change; all other PSR bits pass through unchanged.
  - Next state DONE.
- DONE: `done`=1, `rf_load`=0, `result`=`val_q`. Next state IDLE.
- Illegal op with `start` in IDLE: `error`=1 for the following cycle, stay IDLE, no port activity, `result` unchanged.
- `start` while `busy` is ignored; it is not queued.
- `rf_load` is high only in WR_DST and WR_PSR, for exactly one cycle each.

## Timing
- Reset state (at the edge where `reset`=1):
  - State IDLE.
  - `rf_sel`=0, `rf_load`=0, `rf_wdata`=0.
  - `busy`=0, `done`=0, `error`=0, `result`=0.
  - `val_q`=0, `psr_q`=0.
- Reset mid-operation: IDLE on the next edge. No further writes are issued, `done` is not pulsed, and a partially completed transfer is not rolled back.
- Latency, counted from the accept edge (cycle 0) to the `done` cycle inclusive:
  - Transfer with flags: 7 cycles.
  - TXS: 4 cycles.
  - Immediate: 5 cycles.
- `done` and `busy` are both high in DONE. `busy` falls the next cycle.
- A new `start` is accepted in the first IDLE cycle after DONE, so back-to-back ops have no extra gap.
- `error` asserts one cycle after the illegal `start`. `busy` stays low throughout.

## Test plan
- Reset, then preload A=0x80 and PSR=0x01. Issue TAX.
  - Port sequence: sel0 rd, sel0 rd, sel1 wr 0x80, sel6 rd, sel6 rd, sel6 wr 0x81.
  - `done` on cycle 7; `result`=0x80.
- Preload X=0x00, PSR=0xFF. Issue TXS.
  - Single write: SP=0x00.
  - PSR stays 0xFF, with no PSR access.
  - `done` on cycle 4.
- PSR=0x82. Issue LDY# with `imm`=0x05.
  - Y=0x05, PSR written 0x00.
  - `done` on cycle 5.
- Assert `start` with `op`=12.
  - `error` pulses one cycle.
  - `busy`=0, `rf_load` never high, `result` unchanged.
- Assert `reset` in WR_DST of a TAY.
  - Next cycle: IDLE, all outputs 0, no PSR write, no `done`.
- Hold `start` high continuously with TYA then TXA.
  - Second op is accepted only in the IDLE cycle after the first DONE.
  - Extra `start` cycles during `busy` are ignored.
